mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Two-requester round-robin arbiter for one block-RAM port, 1024x16 by default, with a built-in clear sequencer.
- Lets the switch-driven write logic and a future display/readback scanner share one memory port.
- Also provides a hardware "zero all memory" sweep.
- Sits between the requesters and the memory's single enable/write-enable/address/data port.

Parameters:
ADDR_W, 10, memory address width; depth = 2^ADDR_W
DATA_W, 16, memory data width
RD_LAT, 1, memory read latency in cycles (mem_dout valid RD_LAT cycles after mem_en); legal values 1..4

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-high reset
req_valid  input  2  per-requester request valid; bit i = requester i
req_we  input  2  per-requester 1 = write, 0 = read
req_addr  input  2*ADDR_W  per-requester address; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  2*DATA_W  per-requester write data; requester i at [i*DATA_W +: DATA_W]
req_ready  output  2  per-requester grant; a transfer occurs when req_valid[i] && req_ready[i]
rsp_valid  output  2  per-requester read-data strobe
rsp_rdata  output  DATA_W  read data, shared; valid only when a rsp_valid bit is set
clear_start  input  1  one-cycle pulse that starts the memory clear sweep
clear_busy  output  1  high while the sweep runs
clear_done  output  1  one-cycle pulse after the last clear write is issued
mem_en  output  1  memory port enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_din  output  DATA_W  memory write data
mem_dout  input  DATA_W  memory read data

Behaviour:
Reset values:
- FSM = IDLE; priority pointer = 0 (requester 0 favoured).
- mem_en, mem_we, mem_addr, mem_din = 0.
- rsp_valid = 0, with the response tag pipeline flushed; clear_busy = 0, clear_done = 0.

FSM states: IDLE, CLEAR.

Arbitration (IDLE only):
- req_ready is combinational and one-hot or zero; it is asserted only for a requester with req_valid high.
- Both valid: grant the requester pointed to by the priority pointer.
- One valid: grant that requester.
- After any grant to requester i, the pointer becomes 1-i.
- If clear_start is high, req_ready = 0 in that same cycle; clear has priority.
- No grant in CLEAR.

Memory command:
- Registered. A grant at edge t drives mem_en=1, mem_we=req_we, mem_addr, and mem_din during cycle t+1.
- mem_en = 0 in any cycle with no command.
- Throughput is one command per cycle.

Read response:
- A read granted at edge t asserts rsp_valid[i] during cycle t+1+RD_LAT, with rsp_rdata = mem_dout passed through combinationally.
- A 1+RD_LAT-deep shift register carries {valid, requester id}.
- Writes produce no response.
- At most one rsp_valid bit is set in any cycle.

Clear sweep:
- clear_start in IDLE -> CLEAR at the next edge; clear_busy = 1 from that cycle on.
- In CLEAR, the block issues mem_en=1, mem_we=1, mem_din=0 for addresses 0, 1, ... 2^ADDR_W-1, one per cycle, in consecutive cycles.
- The cycle after the last write command: state = IDLE, clear_busy = 0, clear_done = 1 for one cycle.
- clear_start while in CLEAR is ignored.

Boundaries:
- Reads already in flight when a clear starts complete normally.
- A reset mid-clear aborts the sweep immediately: no clear_done, and the memory is left partially cleared.
- The clear address counter is internal and is ADDR_W+1 bits wide so the termination test does not wrap.
- Requester address/data values are passed through unmodified; there is no wrap logic.

Test Plan:
1. Write and read back: requester 0 writes 0xBEEF to 0x3FF (accepted at edge t). Requester 1 then reads 0x3FF, accepted at edge t+1 -> mem_we=1 in cycle t+1; rsp_valid[1]=1 with rsp_rdata=0xBEEF in cycle t+3 (RD_LAT=1).
2. Contention: both requesters hold valid for 6 cycles after reset -> grants 0,1,0,1,0,1. One requester alone for 3 cycles -> granted every cycle.
3. Clear sweep: pulse clear_start -> clear_busy high for exactly 1024 cycles; mem_addr runs 0..1023 with mem_din=0; clear_done pulses once. All later reads return 0x0000.
4. Collision: clear_start and req_valid[0] in the same cycle -> req_ready=0 that cycle; request granted the cycle after clear_busy falls.
5. Reset mid-clear: reset at sweep address 500 -> all outputs return to reset values the next cycle; clear_done never pulses; addresses >= 500 keep their old data.
6. Latency: RD_LAT=3, pipelined reads from both requesters on back-to-back cycles -> each rsp_valid arrives exactly 4 cycles after its grant, tagged to the correct requester.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two requesters,
// with a built-in sweep that zeroes the whole memory.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    input  logic                clear_start,
    output logic                clear_busy,
    output logic                clear_done,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic                ptr;
    logic [ADDR_W:0]     clr_cnt;
    logic [1:0]          gnt;
    logic                gnt_id;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [RD_LAT:0]     tag_v;
    logic [RD_LAT:0]     tag_id;

    // Clear request wins over both requesters in the cycle it arrives.
    always_comb begin
        gnt = 2'b00;
        if (state == IDLE && !clear_start) begin
            case (req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign req_ready = gnt;
    assign gnt_id    = gnt[1];
    assign sel_we    = req_we[gnt_id];
    assign sel_addr  = gnt_id ? req_addr[2*ADDR_W-1:ADDR_W]
                              : req_addr[ADDR_W-1:0];
    assign sel_wdata = gnt_id ? req_wdata[2*DATA_W-1:DATA_W]
                              : req_wdata[DATA_W-1:0];

    assign rsp_valid = !tag_v[RD_LAT] ? 2'b00
                     : (tag_id[RD_LAT] ? 2'b10 : 2'b01);
    assign rsp_rdata = mem_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            clear_done <= 1'b0;
            tag_v      <= {tag_v[RD_LAT-1:0], |gnt & ~sel_we};
            tag_id     <= {tag_id[RD_LAT-1:0], gnt_id};
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_addr   <= '0;
                        mem_din    <= '0;
                        clr_cnt    <= (ADDR_W+1)'(1);
                    end else if (|gnt) begin
                        mem_en   <= 1'b1;
                        mem_we   <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_wdata;
                        ptr      <= ~gnt_id;
                    end
                end
                CLEAR: begin
                    // clr_cnt is the next address; its MSB marks the end.
                    if (clr_cnt[ADDR_W]) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= clr_cnt[ADDR_W-1:0];
                        mem_din  <= '0;
                        clr_cnt  <= clr_cnt + (ADDR_W+1)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
